// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared FSM encoding, entry type and sizing helpers for the fetch unit
package ifetch_pkg;

  typedef enum logic [0:0] {
    ST_LOOKUP = 1'b0,
    ST_MISS   = 1'b1
  } fetch_state_e;

  // An all-zero instruction word marks the end of the program stream.
  localparam int INST_NOP_END = 0;

  localparam int FQ_ADDR_W = 32;
  localparam int FQ_INST_W = 32;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_INST_W-1:0] inst;
  } fq_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_fq.sv
// rtl/ifetch_fq.sv - synchronous fetch FIFO with flush and occupancy count
module ifetch_fq
  import ifetch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign do_push = push_i & ~flush_i & (count_q != FULL_CNT);
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o     = (count_q != '0);
  assign head_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch unit: PC sequencing, direct-mapped icache, fetch queue (IFETCH_PERF_CNT_EN adds hit/miss counters)
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                IC_SETS  = 256,
  parameter int                FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_data,
  input  logic              iss_ready,
  output logic              iss_valid,
  output logic [INST_W-1:0] iss_inst,
  output logic [ADDR_W-1:0] iss_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = clog2(IC_SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int CNT_W = cnt_w(FQ_DEPTH);
  localparam int ENT_W = ADDR_W + INST_W;
  localparam logic [CNT_W-1:0]  FQ_FULL  = CNT_W'(FQ_DEPTH);
  localparam logic [INST_W-1:0] END_INST = INST_W'(INST_NOP_END);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              halted_q, halted_d;
  logic              drop_q, drop_d;

  logic [INST_W-1:0] ic_data_q [IC_SETS];
  logic [TAG_W-1:0]  ic_tag_q  [IC_SETS];
  logic [IC_SETS-1:0] ic_valid_q;

  logic [IDX_W-1:0]  pc_idx, fill_idx;
  logic [TAG_W-1:0]  pc_tag, fill_tag;
  logic [INST_W-1:0] hit_inst;
  logic              hit, lookup_en, fq_full, cache_we, enq;
  logic [INST_W-1:0] enq_inst;

  logic              fq_valid;
  logic [ENT_W-1:0]  fq_head;
  logic [CNT_W-1:0]  fq_count;

  assign pc_idx   = pc_q[2 +: IDX_W];
  assign pc_tag   = pc_q[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_addr_q[2 +: IDX_W];
  assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign hit_inst = ic_data_q[pc_idx];
  assign hit      = ic_valid_q[pc_idx] & (ic_tag_q[pc_idx] == pc_tag);

  // Fullness is the registered count, so a pop this cycle cannot open a lookup slot.
  assign fq_full   = (fq_count == FQ_FULL);
  assign lookup_en = (state_q == ST_LOOKUP) & ~halted_q & ~fq_full & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_LOOKUP;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOOKUP: if (lookup_en && !hit) state_d = ST_MISS;
      ST_MISS:   if (mem_valid) state_d = ST_LOOKUP;
      default:   state_d = ST_LOOKUP;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    halted_d   = halted_q;
    drop_d     = drop_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cache_we   = 1'b0;
    enq        = 1'b0;
    enq_inst   = '0;
    case (state_q)
      ST_LOOKUP: begin
        if (lookup_en && hit) begin
          if (hit_inst == END_INST) begin
            halted_d = 1'b1;
          end else begin
            enq      = 1'b1;
            enq_inst = hit_inst;
            pc_d     = pc_q + ADDR_W'(4);
          end
        end else if (lookup_en) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      ST_MISS: begin
        if (mem_valid) begin
          cache_we  = 1'b1;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A fill belonging to a flushed path only warms the cache.
          if (!drop_q && !redirect_valid) begin
            if (mem_data == END_INST) begin
              halted_d = 1'b1;
            end else begin
              enq      = 1'b1;
              enq_inst = mem_data;
              pc_d     = pc_q + ADDR_W'(4);
            end
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      halted_q   <= 1'b0;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ic_valid_q <= '0;
    end else if (rdy) begin
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (cache_we) ic_valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && cache_we) begin
      ic_data_q[fill_idx] <= mem_data;
      ic_tag_q[fill_idx]  <= fill_tag;
    end
  end

  ifetch_fq #(
    .DATA_W (ENT_W),
    .DEPTH  (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (rdy & redirect_valid),
    .push_i      (rdy & enq),
    .push_data_i ({pc_q, enq_inst}),
    .pop_i       (rdy & iss_ready & ~redirect_valid),
    .valid_o     (fq_valid),
    .head_data_o (fq_head),
    .count_o     (fq_count)
  );

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign iss_valid = fq_valid;
  assign iss_pc    = fq_head[ENT_W-1 -: ADDR_W];
  assign iss_inst  = fq_head[INST_W-1:0];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = lookup_en & hit;
  assign miss_evt = lookup_en & ~hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (hit_evt && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        iss_ready = 1'b0;
  logic        iss_valid;
  logic [31:0] iss_inst;
  logic [31:0] iss_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data),
    .iss_ready      (iss_ready),
    .iss_valid      (iss_valid),
    .iss_inst       (iss_inst),
    .iss_pc         (iss_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always @(negedge clk) begin
    if (rst && rdy && iss_valid && iss_ready && !redirect_valid) begin
      log_pc.push_back(iss_pc);
      log_inst.push_back(iss_inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic serve_fill(input logic [31:0] exp_addr, input logic [31:0] data, input string name);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_req: mem_req=%b required 1 (timeout)", name, mem_req);
    end else begin
      vectors++;
      if (mem_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL %s_addr: mem_addr=%h required %h", name, mem_addr, exp_addr);
      end
      mem_valid = 1'b1;
      mem_data  = data;
      tick();
      mem_valid = 1'b0;
      mem_data  = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({mem_req, mem_addr, iss_valid, iss_inst, iss_pc} !== 98'b0) begin
      miscompares++;
      $display("FAIL reset: req=%b addr=%h v=%b inst=%h pc=%h required all zero",
               mem_req, mem_addr, iss_valid, iss_inst, iss_pc);
    end
    rst = 1'b1;
  endtask

  task automatic test_cold_start();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] got;
    iss_ready = 1'b1;
    log_pc.delete();
    log_inst.delete();
    serve_fill(32'h0, 32'h13, "cold0");
    serve_fill(32'h4, 32'h13, "cold4");
    serve_fill(32'h8, 32'h13, "cold8");
    serve_fill(32'hC, 32'h13, "coldC");
    repeat (3) tick();
    vectors++;
    if (log_pc.size() != 4) begin
      miscompares++;
      $display("FAIL cold_count: issued %0d required 4", log_pc.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
      vectors++;
      if (got !== exp_pc[i] || (i < log_inst.size() && log_inst[i] !== 32'h13)) begin
        miscompares++;
        $display("FAIL cold_issue%0d: pc=%h required %h", i, got, exp_pc[i]);
      end
    end
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL cold_next_miss: req=%b addr=%h required 1 00000010", mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect_miss();
    redirect(32'h100);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_hold: req=%b addr=%h v=%b required 1 00000010 0", mem_req, mem_addr, iss_valid);
    end
    log_pc.delete();
    log_inst.delete();
    serve_fill(32'h10, 32'h13, "drop10");
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_dropped: iss_valid=%b required 0", iss_valid);
    end
    serve_fill(32'h100, 32'h00A0_0093, "redir100");
    serve_fill(32'h104, 32'h0, "halt104");
    repeat (3) tick();
    vectors++;
    if (log_pc.size() != 1 || log_pc[0] !== 32'h100 || log_inst[0] !== 32'h00A0_0093) begin
      miscompares++;
      $display("FAIL redir_issue: count=%0d first_pc=%h required 1 00000100",
               log_pc.size(), (log_pc.size() > 0) ? log_pc[0] : 32'hDEAD_BEEF);
    end
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_halt: mem_req=%b required 0", mem_req);
    end
  endtask

  task automatic test_hit_stream();
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] got;
    iss_ready = 1'b0;
    redirect(32'h0);
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_flush0: iss_valid=%b required 0", iss_valid);
    end
    tick();
    vectors++;
    if (iss_valid !== 1'b1 || iss_pc !== 32'h0 || iss_inst !== 32'h13 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_first: v=%b pc=%h inst=%h req=%b required 1 0 13 0", iss_valid, iss_pc, iss_inst, mem_req);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_nomem%0d: mem_req=%b required 0", i, mem_req);
      end
    end
    vectors++;
    if (iss_valid !== 1'b1 || iss_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL hit_stall_head: v=%b pc=%h required 1 0", iss_valid, iss_pc);
    end
    redirect(32'h4);
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_flush_full: iss_valid=%b required 0", iss_valid);
    end
    tick();
    vectors++;
    if (iss_valid !== 1'b1 || iss_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL hit_refill: v=%b pc=%h required 1 4", iss_valid, iss_pc);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_full_nomem%0d: mem_req=%b required 0", i, mem_req);
      end
    end
    log_pc.delete();
    log_inst.delete();
    iss_ready = 1'b1;
    tick();
    tick();
    serve_fill(32'h14, 32'h0, "hit_halt14");
    repeat (3) tick();
    vectors++;
    if (log_pc.size() != 4) begin
      miscompares++;
      $display("FAIL hit_drain_count: issued %0d required 4", log_pc.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
      vectors++;
      if (got !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL hit_drain%0d: pc=%h required %h", i, got, exp_pc[i]);
      end
    end
  endtask

  task automatic test_alias();
    iss_ready = 1'b1;
    log_pc.delete();
    log_inst.delete();
    redirect(32'h400);
    serve_fill(32'h400, 32'h0050_0093, "alias400");
    serve_fill(32'h404, 32'h0, "alias404");
    redirect(32'h0);
    serve_fill(32'h0, 32'h13, "alias_evict0");
    serve_fill(32'h4, 32'h0, "alias_evict4");
    repeat (3) tick();
    vectors++;
    if (log_pc.size() != 2 || log_pc[0] !== 32'h400 || log_inst[0] !== 32'h0050_0093 ||
        log_pc[1] !== 32'h0 || log_inst[1] !== 32'h13) begin
      miscompares++;
      $display("FAIL alias_issue: count=%0d required 2 entries 00000400,00000000", log_pc.size());
    end
  endtask

  task automatic test_zero_inst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    iss_ready = 1'b1;
    log_pc.delete();
    log_inst.delete();
    serve_fill(32'h0, 32'h13, "zero0");
    serve_fill(32'h4, 32'h13, "zero4");
    serve_fill(32'h8, 32'h0, "zero8");
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_halt%0d: mem_req=%b required 0", i, mem_req);
      end
    end
    vectors++;
    if (log_pc.size() != 2 || log_pc[0] !== 32'h0 || log_pc[1] !== 32'h4 || iss_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_issue: count=%0d v=%b required 2 entries 0,4 and v=0", log_pc.size(), iss_valid);
    end
    redirect(32'h20);
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL zero_resume: req=%b addr=%h required 1 00000020", mem_req, mem_addr);
    end
  endtask

  task automatic test_stall_reset();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iss_ready = i[0];
      tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h20 || iss_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d: req=%b addr=%h v=%b required 1 00000020 0", i, mem_req, mem_addr, iss_valid);
      end
    end
    rdy = 1'b1;
    iss_ready = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL stall_resume: req=%b addr=%h required 1 00000020", mem_req, mem_addr);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (mem_req !== 1'b0 || iss_valid !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL miss_reset: req=%b v=%b addr=%h required 0 0 0", mem_req, iss_valid, mem_addr);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_refetch: req=%b addr=%h required 1 0", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_redirect_miss();
    test_hit_stream();
    test_alias();
    test_zero_inst();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
